// File: rtl/spi_controller.sv
// SPI mode-0 master that issues 16-bit {write, addr[6:0], data[7:0]} frames MSB-first.
// All outputs are registered. The state holds the phase and a shared counter times each phase.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [15:0]      frame_q;
  logic [3:0]       nxt_idx;
  logic             load;
  logic             sclk_d, copi_d, ncs_d, busy_d, done_d, ready_d;

  // Bit position of the next copi value, MSB first (only used while bit_q < 15).
  assign nxt_idx = 4'(5'd14 - bit_q);

  // Control and output registers; async reset forces the bus idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      ncs       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sclk      <= sclk_d;
      copi      <= copi_d;
      ncs       <= ncs_d;
      busy      <= busy_d;
      done      <= done_d;
      req_ready <= ready_d;
    end
  end

  // Frame capture at accept; request inputs are never sampled again until the next accept.
  always_ff @(posedge clk) begin
    if (load) frame_q <= {req_write, req_addr, req_data};
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sclk_d  = sclk;
    copi_d  = copi;
    ncs_d   = ncs;
    busy_d  = busy;
    done_d  = 1'b0;
    ready_d = req_ready;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          load    = 1'b1;
          state_d = SETUP;
          cnt_d   = '0;
          ncs_d   = 1'b0;
          copi_d  = req_write;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk;
          // Falling edge: advance to the next bit, or finish after bit 15.
          if (sclk) begin
            if (bit_q == 5'd15) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 5'd1;
              copi_d = frame_q[nxt_idx];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: default instance plus a CLK_DIV=6/CS_SETUP=1/CS_HOLD=3 instance.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr  = '0;
  logic [7:0] req_data  = '0;

  logic ready_a, busy_a, done_a, sclk_a, copi_a, ncs_a;
  logic ready_b, busy_b, done_b, sclk_b, copi_b, ncs_b;

  logic sel = 1'b0;
  logic m_ready, m_busy, m_done, m_sclk, m_copi, m_ncs;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  spi_controller dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .busy(busy_a), .done(done_a), .sclk(sclk_a), .copi(copi_a), .ncs(ncs_a)
  );

  spi_controller #(.CLK_DIV(6), .CS_SETUP(1), .CS_HOLD(3), .CS_GAP(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .copi(copi_b), .ncs(ncs_b)
  );

  assign m_ready = sel ? ready_b : ready_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_sclk  = sel ? sclk_b  : sclk_a;
  assign m_copi  = sel ? copi_b  : copi_a;
  assign m_ncs   = sel ? ncs_b   : ncs_a;

  // Expected timing of the watched instance (hand-computed).
  int exp_div, exp_setup, exp_low;
  assign exp_div   = sel ? 6 : 4;
  assign exp_setup = sel ? 1 : 2;
  assign exp_low   = sel ? 196 : 132;

  // Monitor state
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  logic        in_frame = 1'b0, done_pend = 1'b0, have_prev = 1'b0;
  logic        viol_ph, viol_cp, viol_ctl;
  logic [15:0] shreg, exp_f;
  int          low_cnt, rises, first_rise, hi_len, lo_len, since_fall, hi_run;

  // Monitor: samples on the falling clock edge, rebuilds each frame and checks it against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (in_frame && exp_q.size() > 0) exp_f = exp_q.pop_front();
      in_frame  = 1'b0;
      done_pend = 1'b0;
      have_prev = 1'b0;
      hi_run    = 0;
    end else begin
      if (in_frame || done_pend) since_fall++;
      if (m_done) begin
        total++;
        if (!done_pend || since_fall != exp_low + 4 || !m_ready || m_busy) begin
          bad++;
          $display("FAIL done: pend=%0d cycles=%0d ready=%0d busy=%0d, want pend=1 cycles=%0d ready=1 busy=0",
                   done_pend, since_fall, m_ready, m_busy, exp_low + 4);
        end
        done_pend = 1'b0;
      end
      if (prev_ncs && !m_ncs && !in_frame) begin
        if (have_prev) begin
          total++;
          if (hi_run < 5) begin
            bad++;
            $display("FAIL ncs_gap: high %0d cycles, want >= 5", hi_run);
          end
        end
        in_frame = 1'b1; low_cnt = 0; rises = 0; first_rise = -1; shreg = '0;
        hi_len = 0; lo_len = 0; since_fall = 0;
        viol_ph = 1'b0; viol_cp = 1'b0; viol_ctl = 1'b0;
      end
      if (in_frame && !m_ncs) begin
        low_cnt++;
        if (m_ready || !m_busy) viol_ctl = 1'b1;
        if (m_sclk) hi_len++; else lo_len++;
        if (!prev_sclk && m_sclk) begin
          rises++;
          shreg = {shreg[14:0], m_copi};
          if (rises == 1) first_rise = since_fall;
          else if (lo_len != exp_div) viol_ph = 1'b1;
          lo_len = 0;
        end
        if (prev_sclk && !m_sclk) begin
          if (hi_len != exp_div) viol_ph = 1'b1;
          hi_len = 0;
        end
        if (m_copi != prev_copi && !(prev_sclk && !m_sclk) && low_cnt > 1) viol_cp = 1'b1;
      end else if (in_frame && m_ncs) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL frame: got %h with no expected entry", shreg);
        end else begin
          exp_f = exp_q.pop_front();
          total++;
          if (shreg !== exp_f) begin
            bad++;
            $display("FAIL frame: got %h want %h", shreg, exp_f);
          end
        end
        total++;
        if (rises != 16 || low_cnt != exp_low || first_rise != exp_setup + exp_div) begin
          bad++;
          $display("FAIL timing: rises=%0d ncs_low=%0d first_rise=%0d, want 16 %0d %0d",
                   rises, low_cnt, first_rise, exp_low, exp_setup + exp_div);
        end
        total++;
        if (viol_ph || viol_cp || viol_ctl) begin
          bad++;
          $display("FAIL shape: phase_err=%0d copi_err=%0d ctl_err=%0d, want 0 0 0",
                   viol_ph, viol_cp, viol_ctl);
        end
        total++;
        if (m_copi !== 1'b0 || m_sclk !== 1'b0) begin
          bad++;
          $display("FAIL idle_lines: copi=%0d sclk=%0d, want 0 0", m_copi, m_sclk);
        end
        in_frame  = 1'b0;
        done_pend = 1'b1;
        have_prev = 1'b1;
        hi_run    = 1;
      end else if (!in_frame && m_ncs) begin
        hi_run++;
      end
    end
    prev_ncs  = m_ncs;
    prev_sclk = m_sclk;
    prev_copi = m_copi;
  end

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] e, input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    while (!m_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL accept_timeout: ready=%0d, want 1", m_ready);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done(input logic toggle);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (m_done) break;
      if (toggle) begin
        req_addr  = ~req_addr;
        req_data  = req_data + 8'h5B;
        req_write = ~req_write;
      end
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL done_timeout: done=%0d, want 1", m_done);
    end
  endtask

  initial begin
    int n;
    int r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m_ncs, m_sclk, m_copi, m_ready, m_busy, m_done} !== 6'b100100) begin
      bad++;
      $display("FAIL reset_state: {ncs,sclk,copi,ready,busy,done}=%b want 100100",
               {m_ncs, m_sclk, m_copi, m_ready, m_busy, m_done});
    end
    @(posedge clk); #1 rst = 1'b0;

    // Single write 0x00 <- 0xA5, then two register writes.
    send(1'b1, 7'h00, 8'hA5, 16'h80A5, 1'b0); wait_done(1'b0);
    send(1'b1, 7'h00, 8'h3C, 16'h803C, 1'b0); wait_done(1'b0);
    send(1'b1, 7'h01, 8'hF0, 16'h81F0, 1'b0); wait_done(1'b0);

    // Three requests with req_valid held high.
    send(1'b0, 7'h7F, 8'h5A, 16'h7F5A, 1'b1);
    send(1'b1, 7'h55, 8'h0F, 16'hD50F, 1'b1);
    send(1'b1, 7'h2A, 8'hC3, 16'hAAC3, 1'b0);
    wait_done(1'b0);

    // Request inputs toggled every cycle while busy.
    send(1'b1, 7'h7F, 8'hFF, 16'hFFFF, 1'b0); wait_done(1'b1);

    // Reset at the 7th sclk rise, then a clean frame.
    send(1'b1, 7'h12, 8'h34, 16'h9234, 1'b0);
    n = 0; r = 0;
    while (r < 7 && n < 3000) begin
      @(negedge clk);
      if (m_sclk && !prev_sclk) r++;
      n++;
    end
    total++;
    if (m_ncs !== 1'b0 || m_sclk !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: ncs=%0d sclk=%0d rises=%0d, want 0 1 7", m_ncs, m_sclk, r);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({m_ncs, m_sclk, m_copi, m_ready, m_busy, m_done} !== 6'b100100) begin
      bad++;
      $display("FAIL async_reset: {ncs,sclk,copi,ready,busy,done}=%b want 100100",
               {m_ncs, m_sclk, m_copi, m_ready, m_busy, m_done});
    end
    @(posedge clk); @(negedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (200) @(negedge clk);
    send(1'b0, 7'h00, 8'h00, 16'h0000, 1'b0); wait_done(1'b0);
    send(1'b1, 7'h12, 8'h34, 16'h9234, 1'b0); wait_done(1'b0);

    // Slower divider instance.
    @(negedge clk);
    rst = 1'b1;
    sel = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    send(1'b1, 7'h00, 8'hA5, 16'h80A5, 1'b0); wait_done(1'b0);
    send(1'b1, 7'h55, 8'h0F, 16'hD50F, 1'b0); wait_done(1'b0);

    repeat (10) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
